tick_sched_ctrl: RTL and testbench

//   Run-control sequencer for the programmable timebase that paces AWG sample/step updates.

---
 rtl/tick_sched_ctrl.sv | 125 ++++++++++++
 tb/tb_tick_sched_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tick_sched_ctrl
// Description : Run-control sequencer for the AWG timebase. It holds a shadow
//               period/burst config, paces one-cycle tick pulses, counts
//               them, and ends finite bursts with a done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_sched_ctrl #(
    parameter int          CNT_W          = 28,
    parameter int          BURST_W        = 16,
    parameter int unsigned DEFAULT_PERIOD = 119999999
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               start,
    input  logic               stop,
    output logic               tick,
    output logic [BURST_W-1:0] tick_cnt,
    output logic               busy,
    output logic               done
);

    localparam logic [CNT_W-1:0] c_default_period = CNT_W'(DEFAULT_PERIOD);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_loop;
    logic [CNT_W-1:0]     w_loop_nxt;
    logic [CNT_W-1:0]     r_period;
    logic [CNT_W-1:0]     w_period_nxt;
    logic [BURST_W-1:0]   r_burst;
    logic [BURST_W-1:0]   w_burst_nxt;
    logic [BURST_W-1:0]   r_tick_cnt;
    logic [BURST_W-1:0]   w_tick_cnt_nxt;
    logic [BURST_W-1:0]   w_cnt_inc;
    logic                 r_tick;
    logic                 w_tick_nxt;
    logic                 r_done;
    logic                 w_done_nxt;

    assign w_cnt_inc = r_tick_cnt + BURST_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_loop     <= '0;
            r_period   <= c_default_period;
            r_burst    <= '0;
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_loop     <= w_loop_nxt;
            r_period   <= w_period_nxt;
            r_burst    <= w_burst_nxt;
            r_tick_cnt <= w_tick_cnt_nxt;
            r_tick     <= w_tick_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_loop_nxt     = r_loop;
        w_period_nxt   = r_period;
        w_burst_nxt    = r_burst;
        w_tick_cnt_nxt = r_tick_cnt;
        w_tick_nxt     = 1'b0;
        w_done_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Config latched on the start edge applies to the run it launches.
                if (cfg_valid) begin
                    w_period_nxt = cfg_period;
                    w_burst_nxt  = cfg_burst;
                end
                if (start && !stop) begin
                    w_state_nxt    = S_RUN;
                    w_loop_nxt     = '0;
                    w_tick_cnt_nxt = '0;
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                    w_loop_nxt  = '0;
                end else if (r_loop == r_period) begin
                    w_loop_nxt     = '0;
                    w_tick_nxt     = 1'b1;
                    w_tick_cnt_nxt = w_cnt_inc;
                    // Last tick of a finite burst carries done with it.
                    if ((r_burst != '0) && (w_cnt_inc == r_burst)) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_loop_nxt = r_loop + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign cfg_ready = (r_state == S_IDLE);
    assign busy      = (r_state == S_RUN);
    assign tick      = r_tick;
    assign done      = r_done;
    assign tick_cnt  = r_tick_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tick_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tick_sched_ctrl
// Description : Self-checking bench for tick_sched_ctrl; a tick-arithmetic
//               reference model is compared against the DUT every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_sched_ctrl;

    localparam int CNT_W   = 28;
    localparam int BURST_W = 16;
    localparam int DEF_P   = 9;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [CNT_W-1:0]   cfg_period = '0;
    logic [BURST_W-1:0] cfg_burst = '0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               tick;
    logic [BURST_W-1:0] tick_cnt;
    logic               busy;
    logic               done;

    always #5 clk = ~clk;

    tick_sched_ctrl #(
        .CNT_W          (CNT_W),
        .BURST_W        (BURST_W),
        .DEFAULT_PERIOD (DEF_P)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_burst  (cfg_burst),
        .start      (start),
        .stop       (stop),
        .tick       (tick),
        .tick_cnt   (tick_cnt),
        .busy       (busy),
        .done       (done)
    );

    int     vectors     = 0;
    int     miscompares = 0;
    longint cyc         = 0;

    // Reference model: a run is described by its start cycle and (P, B);
    // tick k of the run lands in cycle start + k*(P+1) + 1.
    bit     m_run  = 1'b0;
    longint m_p    = DEF_P;
    longint m_b    = 0;
    longint m_s    = 0;
    longint m_cnt  = 0;
    bit     m_tick = 1'b0;
    bit     m_done = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        longint n;
        longint k;
        if (rst) begin
            m_run = 1'b0; m_p = DEF_P; m_b = 0; m_cnt = 0;
            m_tick = 1'b0; m_done = 1'b0;
        end else if (!m_run) begin
            m_tick = 1'b0; m_done = 1'b0;
            if (cfg_valid) begin
                m_p = longint'(cfg_period);
                m_b = longint'(cfg_burst);
            end
            if (start && !stop) begin
                m_run = 1'b1; m_s = cyc - 1; m_cnt = 0;
            end
        end else if (stop) begin
            m_run = 1'b0; m_tick = 1'b0; m_done = 1'b0;
        end else begin
            n = cyc - m_s - 1;
            if (n > 0 && (n % (m_p + 1)) == 0) begin
                k      = n / (m_p + 1);
                m_tick = 1'b1;
                m_cnt  = k % (longint'(1) << BURST_W);
                m_done = (m_b != 0) && (k == m_b);
                if (m_done) m_run = 1'b0;
            end else begin
                m_tick = 1'b0; m_done = 1'b0;
            end
        end
    endtask

    // Advance one clock, update the model, then compare away from the edge.
    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        chk("tick",      longint'(tick),      longint'(m_tick));
        chk("done",      longint'(done),      longint'(m_done));
        chk("tick_cnt",  longint'(tick_cnt),  m_cnt);
        chk("busy",      longint'(busy),      longint'(m_run));
        chk("cfg_ready", longint'(cfg_ready), longint'(!m_run));
    endtask

    task automatic load_cfg(input int p, input int b);
        cfg_valid  = 1'b1;
        cfg_period = CNT_W'(p);
        cfg_burst  = BURST_W'(b);
        step();
        cfg_valid  = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
    endtask

    initial begin
        // Reset state
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_cfg_ready", longint'(cfg_ready), 1);
        chk("rst_tick_cnt",  longint'(tick_cnt),  0);
        chk("rst_busy",      longint'(busy),      0);

        // Default period 9, no config
        start = 1'b1; step(); start = 1'b0;
        for (int j = 1; j <= 35; j++) begin
            chk("s1_tick", longint'(tick), longint'(j == 11 || j == 21 || j == 31));
            chk("s1_done", longint'(done), 0);
            chk("s1_busy", longint'(busy), 1);
            step();
        end
        do_stop();
        chk("s1_cnt_hold", longint'(tick_cnt), 3);

        // Finite burst: period 4, burst 3
        load_cfg(4, 3);
        start = 1'b1; step(); start = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            chk("s2_tick", longint'(tick), longint'(j == 6 || j == 11 || j == 16));
            chk("s2_done", longint'(done), longint'(j == 16));
            chk("s2_cnt",  longint'(tick_cnt),
                longint'(j < 6 ? 0 : j < 11 ? 1 : j < 16 ? 2 : 3));
            if (j >= 17) begin
                chk("s2_busy",  longint'(busy),      0);
                chk("s2_ready", longint'(cfg_ready), 1);
            end
            step();
        end

        // Period 0 continuous: tick every cycle, counter wraps
        cfg_valid = 1'b1; cfg_period = '0; cfg_burst = '0; start = 1'b1;
        step();
        cfg_valid = 1'b0; start = 1'b0;
        for (int j = 1; j <= 65540; j++) begin
            if (j == 1) chk("s3_tick1", longint'(tick), 0);
            if (j == 2) chk("s3_tick2", longint'(tick), 1);
            if (j == 65536) chk("s3_cnt_max",  longint'(tick_cnt), 65535);
            if (j == 65537) chk("s3_cnt_wrap", longint'(tick_cnt), 0);
            if (j == 65537) chk("s3_tick_wrap", longint'(tick), 1);
            step();
        end
        do_stop();

        // Stop on the edge where a tick would register
        load_cfg(4, 0);
        start = 1'b1; step(); start = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            chk("s4_tick", longint'(tick), longint'(j == 6));
            if (j >= 11) begin
                chk("s4_cnt",  longint'(tick_cnt), 1);
                chk("s4_done", longint'(done),     0);
                chk("s4_busy", longint'(busy),     0);
            end
            stop = (j == 10);
            step();
        end
        stop = 1'b0;

        // Config accepted with start; config offered during RUN is refused
        cfg_valid = 1'b1; cfg_period = CNT_W'(2); cfg_burst = BURST_W'(2); start = 1'b1;
        step();
        cfg_valid = 1'b0; start = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            chk("s5_tick", longint'(tick), longint'(j == 4 || j == 7));
            chk("s5_done", longint'(done), longint'(j == 7));
            if (j == 2) chk("s5_ready_run", longint'(cfg_ready), 0);
            cfg_valid  = (j == 2);
            cfg_period = CNT_W'(7);
            cfg_burst  = BURST_W'(9);
            step();
        end
        cfg_valid = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            chk("s5b_tick", longint'(tick), longint'(j == 4 || j == 7));
            chk("s5b_done", longint'(done), longint'(j == 7));
            step();
        end

        // Reset the cycle before a tick is due
        load_cfg(4, 0);
        start = 1'b1; step(); start = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            if (j == 6) begin
                chk("s6_tick",  longint'(tick),      0);
                chk("s6_cnt",   longint'(tick_cnt),  0);
                chk("s6_busy",  longint'(busy),      0);
                chk("s6_done",  longint'(done),      0);
                chk("s6_ready", longint'(cfg_ready), 1);
            end
            rst = (j == 5);
            step();
        end
        rst = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            chk("s6b_tick", longint'(tick), longint'(j == 11));
            step();
        end
        do_stop();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cfg_valid  = ($urandom % 4) == 0;
            cfg_period = CNT_W'($urandom_range(0, 6));
            cfg_burst  = BURST_W'($urandom_range(0, 4));
            start      = ($urandom % 5) == 0;
            stop       = ($urandom % 23) == 0;
            rst        = ($urandom % 211) == 0;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
